alu_control: RTL and testbench
==============================

# alu_control

Multi-cycle issue controller on the operand/opcode side of the core's ALU. It accepts one RV32 instruction plus register operands per handshake and decodes it into the ALU's 4-bit operation code and operands. It captures the ALU result and returns a writeback result or a branch decision downstream. It sits between register read and writeback and owns all ALU operation encoding.

## Interface
Parameters:
- None.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction and operands valid
- in_ready  out  1  controller can accept; high only in IDLE
- instr  in  32  RV32 instruction word
- rs1_data  in  32  register rs1 value
- rs2_data  in  32  register rs2 value
- operation  out  4  ALU operation code, registered
- alu_x  out  32  ALU X operand, registered
- alu_y  out  32  ALU Y operand, registered
- alu_result  in  32  combinational ALU output for the current operation/alu_x/alu_y
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  32  captured ALU result
- rd  out  5  destination register (instr[11:7])
- wb_en  out  1  write result to rd (0 for branches, illegal, or rd==0)
- branch_taken  out  1  branch condition true
- illegal  out  1  instruction not supported

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111 (unsigned compare, result 1/0), NOR 1100 (unused here).
- Decode (opcode = instr[6:0], funct3 = instr[14:12], funct7 = instr[31:25]):
  - OP 0110011, funct7 0000000: ADD(000)→0010, SLT(010)→0111 signed, SLTU(011)→0111, OR(110)→0001, AND(111)→0000.
  - OP 0110011, funct7 0100000 with funct3 000: SUB→0110.
  - OP-IMM 0010011: ADDI, SLTI, SLTIU, ORI, ANDI, using the same mapping. Y is the sign-extended instr[31:20].
  - BRANCH 1100011: BEQ(000) and BNE(001)→0110. BLT(100) and BGE(101)→0111 signed. BLTU(110) and BGEU(111)→0111.
  - Anything else is illegal: XOR, shifts, other funct7 values, funct3 010/011 on branches, and all other opcodes. Set illegal=1, wb_en=0, branch_taken=0, result=0.
- Signed compare: XOR bit 31 of both X and Y with 1 before issue, so the ALU's unsigned compare yields a signed result.
- Branch resolution: zero = (alu_result == 32'h0), computed internally.
  - BEQ: taken = zero. BNE: taken = !zero.
  - BLT/BLTU: taken = alu_result[0]. BGE/BGEU: taken = !alu_result[0].
- States:
  - IDLE: in_ready=1. On in_valid, latch decode and operands and go to EXEC. Illegal instructions go straight to RESP.
  - EXEC: operation/alu_x/alu_y stable. Capture alu_result, rd, wb_en and branch_taken. Go to RESP.
  - RESP: out_valid=1. All outputs held stable until out_ready, then go to IDLE.
- operation/alu_x/alu_y keep their last values outside EXEC.

## Timing
- Reset values: state IDLE, in_ready=1 after the reset cycle (0 while reset is high), out_valid=0, operation=4'b0010, alu_x=0, alu_y=0, result=0, rd=0, wb_en=0, branch_taken=0, illegal=0.
- Legal instruction accepted at edge N. EXEC runs during cycle N+1. out_valid is high from edge N+2.
- Illegal instruction accepted at edge N: out_valid is high from edge N+1.
- Back-to-back throughput is one instruction per 3 cycles (2 for illegal) when out_ready is held high. The next accept can occur no earlier than the edge after out_valid&&out_ready.
- in_ready is low in EXEC and RESP. in_valid is ignored there, and upstream must hold the instruction.
- out_ready low holds RESP indefinitely, with no output change.
- Reset asserted in any state returns to IDLE on that edge and discards any in-flight instruction. out_valid is low the following cycle.
- Arithmetic is 32-bit modulo 2^32 in the ALU. Overflow is not flagged.

## Test plan
- ADD x3,x1,x2 with rs1=32'hFFFF_FFFF, rs2=1: operation=0010 during EXEC, result=0, rd=3, wb_en=1, out_valid exactly 2 cycles after accept.
- SLT with rs1=32'hFFFF_FFFE (-2), rs2=1: alu_x=32'h7FFF_FFFE, alu_y=32'h8000_0001, result=1. Same operands with SLTU give result=0.
- BNE with rs1=rs2=32'h1234: operation=0110, branch_taken=0, wb_en=0. BGE with rs1=5, rs2=-3 gives branch_taken=1.
- ADDI x0,x1,-1 with rs1=10: alu_y=32'hFFFF_FFFF, result=9, wb_en=0 (rd=0).
- XOR (OP, funct3 100): illegal=1, out_valid one cycle after accept, result=0. Then hold out_ready=0 for 5 cycles: outputs stable, in_ready=0.
- Assert reset during EXEC: next cycle out_valid=0 and state IDLE. A fresh ORI 32'h0F0 on rs1=32'h00F is accepted and returns 32'h0FF.

Source files
------------

// File: rtl/alu_control.sv
// Issue controller in front of the ALU: decodes one RV32 OP/OP-IMM/BRANCH instruction per
// handshake into an ALU code and operands, captures the ALU result and reports writeback/branch.
module alu_control (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [3:0]  operation,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  rd,
    output logic        wb_en,
    output logic        branch_taken,
    output logic        illegal
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_t;

    state_t      r_state, w_next;

    logic [3:0]  r_operation;
    logic [31:0] r_alu_x, r_alu_y, r_result;
    logic [4:0]  r_rd, r_rd_pend;
    logic        r_wb_en, r_branch_taken, r_illegal;
    logic [2:0]  r_funct3;
    logic        r_is_branch;

    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;
    alu_op_t     w_arith_op, w_op;
    logic        w_arith_ok, w_arith_signed;
    logic        w_legal, w_signed, w_is_branch, w_use_imm;
    logic [31:0] w_y_raw, w_x, w_y;
    logic        w_zero, w_cond, w_taken;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];

    // funct3 mapping shared by OP (funct7 = 0) and OP-IMM
    always_comb begin
        w_arith_op     = ALU_ADD;
        w_arith_ok     = 1'b1;
        w_arith_signed = 1'b0;
        case (w_funct3)
            3'b000:  w_arith_op = ALU_ADD;
            3'b010:  begin w_arith_op = ALU_SLT; w_arith_signed = 1'b1; end
            3'b011:  w_arith_op = ALU_SLT;
            3'b110:  w_arith_op = ALU_OR;
            3'b111:  w_arith_op = ALU_AND;
            default: w_arith_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_legal     = 1'b0;
        w_op        = ALU_ADD;
        w_signed    = 1'b0;
        w_is_branch = 1'b0;
        w_use_imm   = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                if (w_funct7 == 7'b0000000) begin
                    w_legal  = w_arith_ok;
                    w_op     = w_arith_op;
                    w_signed = w_arith_signed;
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_legal = 1'b1;
                    w_op    = ALU_SUB;
                end
            end
            7'b0010011: begin
                w_legal   = w_arith_ok;
                w_op      = w_arith_op;
                w_signed  = w_arith_signed;
                w_use_imm = 1'b1;
            end
            7'b1100011: begin
                w_is_branch = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001: begin w_legal = 1'b1; w_op = ALU_SUB; end
                    3'b100, 3'b101: begin w_legal = 1'b1; w_op = ALU_SLT; w_signed = 1'b1; end
                    3'b110, 3'b111: begin w_legal = 1'b1; w_op = ALU_SLT; end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Flipping both sign bits lets the ALU's unsigned SLT produce a signed comparison
    assign w_y_raw = w_use_imm ? {{20{instr[31]}}, instr[31:20]} : rs2_data;
    assign w_x     = rs1_data ^ {w_signed, 31'b0};
    assign w_y     = w_y_raw  ^ {w_signed, 31'b0};

    // funct3[2] picks compare-vs-equality, funct3[0] inverts (BNE/BGE/BGEU)
    assign w_zero  = (alu_result == '0);
    assign w_cond  = r_funct3[2] ? alu_result[0] : w_zero;
    assign w_taken = r_is_branch & (w_cond ^ r_funct3[0]);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = w_legal ? S_EXEC : S_RESP;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_operation    <= ALU_ADD;
            r_alu_x        <= '0;
            r_alu_y        <= '0;
            r_result       <= '0;
            r_rd           <= '0;
            r_rd_pend      <= '0;
            r_wb_en        <= 1'b0;
            r_branch_taken <= 1'b0;
            r_illegal      <= 1'b0;
            r_funct3       <= '0;
            r_is_branch    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_legal) begin
                            r_operation <= w_op;
                            r_alu_x     <= w_x;
                            r_alu_y     <= w_y;
                            r_funct3    <= w_funct3;
                            r_is_branch <= w_is_branch;
                            r_rd_pend   <= instr[11:7];
                        end else begin
                            r_result       <= '0;
                            r_rd           <= instr[11:7];
                            r_wb_en        <= 1'b0;
                            r_branch_taken <= 1'b0;
                            r_illegal      <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_result       <= alu_result;
                    r_rd           <= r_rd_pend;
                    r_wb_en        <= !r_is_branch && (r_rd_pend != '0);
                    r_branch_taken <= w_taken;
                    r_illegal      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (r_state == S_IDLE) && !reset;
    assign out_valid    = (r_state == S_RESP);
    assign operation    = r_operation;
    assign alu_x        = r_alu_x;
    assign alu_y        = r_alu_y;
    assign result       = r_result;
    assign rd           = r_rd;
    assign wb_en        = r_wb_en;
    assign branch_taken = r_branch_taken;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_alu_control.sv
// Directed vector bench for alu_control; a simple behavioural ALU closes the loop on alu_result.
module tb_alu_control;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, rs1_data, rs2_data, alu_x, alu_y, alu_result, result;
    logic [3:0]  operation;
    logic [4:0]  rd;
    logic        wb_en, branch_taken, illegal;

    int n_checks = 0;
    int n_err    = 0;

    logic [3:0]  last_op;
    logic [31:0] last_x, last_y;

    alu_control dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .operation(operation), .alu_x(alu_x), .alu_y(alu_y), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd(rd),
        .wb_en(wb_en), .branch_taken(branch_taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (operation)
            4'b0000: alu_result = alu_x & alu_y;
            4'b0001: alu_result = alu_x | alu_y;
            4'b0010: alu_result = alu_x + alu_y;
            4'b0110: alu_result = alu_x - alu_y;
            4'b0111: alu_result = {31'b0, alu_x < alu_y};
            4'b1100: alu_result = ~(alu_x | alu_y);
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [31:0] instr, rs1, rs2;
        logic [3:0]  op;
        logic [31:0] x, y, res;
        logic [4:0]  rd;
        logic        wb, taken, ill;
        int          hold;
    } vec_t;

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rdn);
        return {f7, 5'd2, 5'd1, f3, rdn, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rdn);
        return {imm, 5'd1, f3, rdn, 7'b0010011};
    endfunction

    function automatic logic [31:0] btype(input logic [2:0] f3);
        return {7'b0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] res, input logic [4:0] r, input logic wb,
                                input logic tk, input logic il, input int hold);
        vec_t v;
        v.instr = i; v.rs1 = a; v.rs2 = b; v.op = op; v.x = x; v.y = y; v.res = res;
        v.rd = r; v.wb = wb; v.taken = tk; v.ill = il; v.hold = hold;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input string tag, input vec_t v);
        @(negedge clk);
        instr = v.instr; rs1_data = v.rs1; rs2_data = v.rs2;
        in_valid = 1'b1; out_ready = 1'b0;
        #1 chk({tag, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        if (!v.ill) begin
            chk({tag, "_exec_out_valid"}, {31'b0, out_valid}, 32'd0);
            chk({tag, "_exec_in_ready"},  {31'b0, in_ready},  32'd0);
            chk({tag, "_operation"}, {28'b0, operation}, {28'b0, v.op});
            chk({tag, "_alu_x"}, alu_x, v.x);
            chk({tag, "_alu_y"}, alu_y, v.y);
            @(posedge clk); #1;
        end
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_result"}, result, v.res);
        chk({tag, "_wb_en"}, {31'b0, wb_en}, {31'b0, v.wb});
        chk({tag, "_taken"}, {31'b0, branch_taken}, {31'b0, v.taken});
        chk({tag, "_illegal"}, {31'b0, illegal}, {31'b0, v.ill});
        if (!v.ill) chk({tag, "_rd"}, {27'b0, rd}, {27'b0, v.rd});
        else begin
            chk({tag, "_op_held"}, {28'b0, operation}, {28'b0, last_op});
            chk({tag, "_x_held"}, alu_x, last_x);
            chk({tag, "_y_held"}, alu_y, last_y);
        end
        for (int c = 0; c < v.hold; c++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_out_valid"}, {31'b0, out_valid}, 32'd1);
            chk({tag, "_hold_in_ready"},  {31'b0, in_ready},  32'd0);
            chk({tag, "_hold_result"}, result, v.res);
            chk({tag, "_hold_illegal"}, {31'b0, illegal}, {31'b0, v.ill});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_done_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_done_in_ready"},  {31'b0, in_ready},  32'd1);
        if (!v.ill) begin
            last_op = v.op; last_x = v.x; last_y = v.y;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[17];
        vec_t v_ori;

        vecs[0]  = mk(rtype(7'b0000000, 3'b000, 5'd3),  32'hFFFF_FFFF, 32'h1,
                      4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         5'd3,  1, 0, 0, 0);
        vecs[1]  = mk(rtype(7'b0000000, 3'b010, 5'd4),  32'hFFFF_FFFE, 32'h1,
                      4'b0111, 32'h7FFF_FFFE, 32'h8000_0001, 32'h1,         5'd4,  1, 0, 0, 0);
        vecs[2]  = mk(rtype(7'b0000000, 3'b011, 5'd5),  32'hFFFF_FFFE, 32'h1,
                      4'b0111, 32'hFFFF_FFFE, 32'h1,         32'h0,         5'd5,  1, 0, 0, 0);
        vecs[3]  = mk(rtype(7'b0100000, 3'b000, 5'd6),  32'd10, 32'd3,
                      4'b0110, 32'd10,        32'd3,         32'd7,         5'd6,  1, 0, 0, 2);
        vecs[4]  = mk(rtype(7'b0000000, 3'b110, 5'd7),  32'hF0, 32'h0F,
                      4'b0001, 32'hF0,        32'h0F,        32'hFF,        5'd7,  1, 0, 0, 0);
        vecs[5]  = mk(rtype(7'b0000000, 3'b111, 5'd8),  32'hFF00, 32'h0FF0,
                      4'b0000, 32'hFF00,      32'h0FF0,      32'h0F00,      5'd8,  1, 0, 0, 0);
        vecs[6]  = mk(btype(3'b001), 32'h1234, 32'h1234,
                      4'b0110, 32'h1234,      32'h1234,      32'h0,         5'd0,  0, 0, 0, 0);
        vecs[7]  = mk(btype(3'b101), 32'd5, 32'hFFFF_FFFD,
                      4'b0111, 32'h8000_0005, 32'h7FFF_FFFD, 32'h0,         5'd0,  0, 1, 0, 0);
        vecs[8]  = mk(btype(3'b000), 32'd7, 32'd7,
                      4'b0110, 32'd7,         32'd7,         32'h0,         5'd0,  0, 1, 0, 0);
        vecs[9]  = mk(btype(3'b110), 32'd1, 32'd2,
                      4'b0111, 32'd1,         32'd2,         32'h1,         5'd0,  0, 1, 0, 0);
        vecs[10] = mk(itype(12'hFFF, 3'b000, 5'd0), 32'd10, 32'h5555_5555,
                      4'b0010, 32'd10,        32'hFFFF_FFFF, 32'd9,         5'd0,  0, 0, 0, 0);
        vecs[11] = mk(itype(12'h000, 3'b010, 5'd9), 32'hFFFF_FFFF, 32'h0,
                      4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1,         5'd9,  1, 0, 0, 0);
        vecs[12] = mk(itype(12'h800, 3'b111, 5'd10), 32'hFFFF_FFFF, 32'h0,
                      4'b0000, 32'hFFFF_FFFF, 32'hFFFF_F800, 32'hFFFF_F800, 5'd10, 1, 0, 0, 0);
        vecs[13] = mk(rtype(7'b0000000, 3'b100, 5'd11), 32'h3, 32'h5,
                      4'b0000, 32'h0,         32'h0,         32'h0,         5'd0,  0, 0, 1, 5);
        vecs[14] = mk(btype(3'b010), 32'h1, 32'h2,
                      4'b0000, 32'h0,         32'h0,         32'h0,         5'd0,  0, 0, 1, 0);
        vecs[15] = mk({20'h12345, 5'd13, 7'b0110111}, 32'h1, 32'h2,
                      4'b0000, 32'h0,         32'h0,         32'h0,         5'd0,  0, 0, 1, 0);
        vecs[16] = mk(rtype(7'b0100000, 3'b111, 5'd14), 32'h1, 32'h2,
                      4'b0000, 32'h0,         32'h0,         32'h0,         5'd0,  0, 0, 1, 0);
        v_ori    = mk(itype(12'h0F0, 3'b110, 5'd12), 32'h00F, 32'h0,
                      4'b0001, 32'h00F,       32'h0F0,       32'h0FF,       5'd12, 1, 0, 0, 0);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready_during_reset", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_operation", {28'b0, operation}, 32'b0010);
        chk("rst_alu_x", alu_x, 32'h0);
        chk("rst_alu_y", alu_y, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_rd", {27'b0, rd}, 32'h0);
        chk("rst_flags", {29'b0, wb_en, branch_taken, illegal}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_in_ready_after", {31'b0, in_ready}, 32'd1);
        last_op = 4'b0010; last_x = '0; last_y = '0;

        for (int i = 0; i < 17; i++) run($sformatf("v%0d", i), vecs[i]);

        // Reset while an ADD sits in EXEC: it must be discarded
        @(negedge clk);
        instr = rtype(7'b0000000, 3'b000, 5'd3); rs1_data = 32'd5; rs2_data = 32'd6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("mid_exec_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_exec_operation", {28'b0, operation}, 32'b0010);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("mid_rst_result", result, 32'h0);
        chk("mid_rst_alu_x", alu_x, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("mid_rst_idle_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("mid_rst_next_out_valid", {31'b0, out_valid}, 32'd0);
        last_op = 4'b0010; last_x = '0; last_y = '0;
        run("ori_after_reset", v_ori);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
